// File: rtl/sort_engine_pkg.sv
// Shared types and helpers for the sort engine blocks.
// Holds the leaf loader state encoding and the lane index width rule.
package sort_engine_pkg;

  typedef enum logic [1:0] {LOAD, DRAIN, FLUSH} loader_state_t;

  localparam int DWIDTH_DEF = 8;

  // A single lane still needs a one-bit index so port widths never collapse to zero.
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/sort_engine_leaf_loader.sv
// Scatters a serial word stream into the leaf lanes of the merge tree, one batch at a time.
// A new batch is only accepted once the lanes are popped and the tree has fully drained.
module sort_engine_leaf_loader
  import sort_engine_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int LEAF_CNT = 16,
  parameter int IDX_W    = lane_idx_w(LEAF_CNT)
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [DWIDTH-1:0]                  data_i,
  input  logic                               data_val_i,
  input  logic                               data_last_i,
  output logic                               data_ready_o,
  output logic [LEAF_CNT-1:0][DWIDTH-1:0]    leaf_data_o,
  output logic [LEAF_CNT-1:0]                leaf_val_o,
  input  logic [LEAF_CNT-1:0]                leaf_ready_i,
  input  logic                               tree_busy_i,
  output logic                               busy_o
);

  loader_state_t       state;
  loader_state_t       state_nxt;
  logic [IDX_W-1:0]    wr_idx;
  logic [LEAF_CNT-1:0] lane_full;
  logic [DWIDTH-1:0]   lane_q    [LEAF_CNT];
  logic                full_q    [LEAF_CNT];
  logic                accept;
  logic                batch_end;

  // Ready depends on state alone, so lane pops never reach the input handshake combinationally.
  assign data_ready_o = (state == LOAD);
  assign busy_o       = (state != LOAD);
  assign accept       = data_val_i & data_ready_o;
  assign batch_end    = accept & ((wr_idx == IDX_W'(LEAF_CNT - 1)) | data_last_i);
  assign leaf_val_o   = (state == DRAIN) ? lane_full : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (batch_end) state_nxt = DRAIN;
      DRAIN:   if (lane_full == '0) state_nxt = FLUSH;
      FLUSH:   if (!tree_busy_i) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= LOAD;
      wr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (batch_end) begin
        wr_idx <= '0;
      end else if (accept) begin
        wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  // Each lane holds its word until popped; unloaded lanes of a short batch stay invalid.
  for (genvar k = 0; k < LEAF_CNT; k++) begin : g_lane
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        lane_q[k] <= '0;
        full_q[k] <= 1'b0;
      end else if (accept && (wr_idx == IDX_W'(k))) begin
        lane_q[k] <= data_i;
        full_q[k] <= 1'b1;
      end else if ((state == DRAIN) && leaf_ready_i[k]) begin
        full_q[k] <= 1'b0;
      end
    end

    assign lane_full[k]   = full_q[k];
    assign leaf_data_o[k] = lane_q[k];
  end

endmodule
